// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU load/store unit on A, register
// save/restore engine on B), the arbiter, and the single-port DataMemory.
interface data_mem_arbiter_if #(
    parameter int MEM_ADDR_BITS = 8,
    parameter int WORD_SIZE     = 16
);
    logic                     req_a;
    logic                     we_a;
    logic [MEM_ADDR_BITS-1:0] addr_a;
    logic [WORD_SIZE-1:0]     wdata_a;
    logic                     done_a;
    logic [WORD_SIZE-1:0]     rdata_a;
    logic                     err_a;

    logic                     req_b;
    logic                     we_b;
    logic [MEM_ADDR_BITS-1:0] addr_b;
    logic [WORD_SIZE-1:0]     wdata_b;
    logic                     done_b;
    logic [WORD_SIZE-1:0]     rdata_b;

    logic                     busy;

    logic                     mem_write_en;
    logic                     mem_read_en;
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [WORD_SIZE-1:0]     mem_write_data;
    logic [WORD_SIZE-1:0]     mem_read_data;

    // Arbiter side
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  mem_read_data,
        output done_a, rdata_a, err_a,
        output done_b, rdata_b,
        output busy,
        output mem_write_en, mem_read_en, mem_addr, mem_write_data
    );

    // Requester and memory side
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output mem_read_data,
        input  done_a, rdata_a, err_a,
        input  done_b, rdata_b,
        input  busy,
        input  mem_write_en, mem_read_en, mem_addr, mem_write_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port
// DataMemory. Serialises one access at a time with round-robin priority and
// blocks port A writes into the reserved register area at the bottom of memory.
module data_mem_arbiter #(
    parameter int MEM_ADDR_BITS  = 8,
    parameter int WORD_SIZE      = 16,
    parameter int RESERVED_WORDS = 16
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);
    localparam logic [MEM_ADDR_BITS-1:0] RESV_LIMIT = MEM_ADDR_BITS'(RESERVED_WORDS);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t                   state;
    logic                     last_grant;
    logic                     lat_port;
    logic                     lat_we;
    logic                     lat_blocked;
    logic [MEM_ADDR_BITS-1:0] lat_addr;
    logic [WORD_SIZE-1:0]     lat_wdata;
    logic                     wr_en_q;
    logic                     rd_en_q;
    logic                     done_a;
    logic                     done_b;
    logic                     err_a;
    logic                     busy;
    logic [WORD_SIZE-1:0]     rdata_a;
    logic [WORD_SIZE-1:0]     rdata_b;

    logic                     grant_b;
    logic                     sel_we;
    logic                     sel_blocked;
    logic [MEM_ADDR_BITS-1:0] sel_addr;
    logic [WORD_SIZE-1:0]     sel_wdata;

    // Pick the winner among pending requests: the port not granted last wins a tie
    always_comb begin
        grant_b     = bus.req_b & (~bus.req_a | (last_grant == PORT_A));
        sel_we      = grant_b ? bus.we_b    : bus.we_a;
        sel_addr    = grant_b ? bus.addr_b  : bus.addr_a;
        sel_wdata   = grant_b ? bus.wdata_b : bus.wdata_a;
        sel_blocked = ~grant_b & bus.we_a & (bus.addr_a < RESV_LIMIT);
    end

    // Access sequencer: IDLE -> ISSUE -> CAPTURE -> DONE, all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= PORT_B;
            lat_port    <= PORT_A;
            lat_we      <= 1'b0;
            lat_blocked <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            err_a       <= 1'b0;
            busy        <= 1'b0;
            rdata_a     <= '0;
            rdata_b     <= '0;
        end else begin
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            err_a   <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        lat_port    <= grant_b;
                        last_grant  <= grant_b;
                        lat_we      <= sel_we;
                        lat_addr    <= sel_addr;
                        lat_wdata   <= sel_wdata;
                        lat_blocked <= sel_blocked;
                        wr_en_q     <= sel_we & ~sel_blocked;
                        rd_en_q     <= ~sel_we;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!lat_we) begin
                        if (lat_port == PORT_B) rdata_b <= bus.mem_read_data;
                        else                    rdata_a <= bus.mem_read_data;
                    end
                    done_a <= (lat_port == PORT_A);
                    done_b <= (lat_port == PORT_B);
                    err_a  <= (lat_port == PORT_A) & lat_blocked;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_write_en   = wr_en_q & ~reset;
    assign bus.mem_read_en    = rd_en_q & ~reset;
    assign bus.mem_addr       = lat_addr;
    assign bus.mem_write_data = lat_wdata;
    assign bus.done_a         = done_a;
    assign bus.done_b         = done_b;
    assign bus.err_a          = err_a;
    assign bus.rdata_a        = rdata_a;
    assign bus.rdata_b        = rdata_b;
    assign bus.busy           = busy;
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of the single-port `DataMemory`. It shares the memory between port A, the CPU load/store unit, and port B, the register save/restore engine. Port B owns the reserved register area at the bottom of memory. The block serialises one access at a time, applies round-robin priority, and blocks port A writes into the reserved area.

## Interface
Parameters:
- `MEM_ADDR_BITS`, from the shared defines header: memory address width.
- `WORD_SIZE`, from the shared defines header: data word width.
- `RESERVED_WORDS`, default 16: words `0..RESERVED_WORDS-1` are reserved for register data and are writable only by port B.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_a` / `req_b` input 1: request. Held high with `we_x`, `addr_x`, `wdata_x` stable until `done_x`.
- `we_a` / `we_b` input 1: 1 = write, 0 = read.
- `addr_a` / `addr_b` input `MEM_ADDR_BITS`: word address.
- `wdata_a` / `wdata_b` input `WORD_SIZE`: write data.
- `done_a` / `done_b` output 1: one-cycle completion pulse, registered.
- `rdata_a` / `rdata_b` output `WORD_SIZE`: read result, registered. Holds its value until the next read completion on that port.
- `err_a` output 1: pulses together with `done_a` when a port-A write was blocked.
- `busy` output 1: high in every state except IDLE.
- `mem_write_en`, `mem_read_en` output 1: drive the DataMemory enables.
- `mem_addr` output `MEM_ADDR_BITS`, `mem_write_data` output `WORD_SIZE`: drive DataMemory address and write data.
- `mem_read_data` input `WORD_SIZE`: from DataMemory. Valid one cycle after `mem_read_en`.

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → DONE → IDLE.
- **IDLE**
  - If any `req` is high, select a winner and latch its `we`, `addr`, `wdata` and port id.
  - Update `last_grant` to the winner and go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Only one request high: that port wins.
  - Both high: the port that is not `last_grant` wins.
  - `last_grant` resets to B, so A wins the first simultaneous request after reset.
- **ISSUE** (exactly one cycle)
  - `mem_addr` = latched address; `mem_write_data` = latched data.
  - Read: `mem_read_en` = 1, `mem_write_en` = 0.
  - Write: `mem_write_en` = 1, `mem_read_en` = 0.
  - Blocked write (port A, `we` = 1, `addr < RESERVED_WORDS`): both enables 0. The access still completes through CAPTURE and DONE.
  - Next state is CAPTURE.
- **CAPTURE**
  - For a read, register `mem_read_data` into the winner's `rdata_x` at the end of this cycle.
  - Set the `done` and `err` registers so they are high during DONE.
- **DONE**
  - `done_x` = 1 for the winner only.
  - `err_a` = 1 only for a blocked port-A write.
  - Next state is IDLE.
  - The requester must drop `req` or present a new request by the next cycle. A `req` still high in IDLE is treated as a new access.
- **Port B** has no address restriction.
- **Outside ISSUE** (or when `reset` = 1): `mem_write_en` and `mem_read_en` are 0, and `mem_addr` / `mem_write_data` are don't-care.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = B.
  - `done_a`, `done_b`, `err_a`, `busy` = 0.
  - `rdata_a`, `rdata_b` = 0.
  - Memory enables = 0.
- Latency: request first seen in IDLE at cycle 0 → ISSUE at cycle 1 → CAPTURE at cycle 2 → `done_x` and `rdata_x` valid at cycle 3.
- Back-to-back throughput: one access every 4 cycles.
- `req` rising outside IDLE is not sampled until the FSM returns to IDLE. Requests are never lost while `req` is held.
- Reset mid-operation:
  - The FSM returns to IDLE at the next edge and the pending access is abandoned.
  - No `done_x` pulse is produced.
  - The memory enables are gated combinationally by `reset`, so a write in an ISSUE cycle with `reset` = 1 does not reach memory.
  - `rdata_x` is cleared to 0.
- Simultaneous `req_a` and `req_b` across consecutive accesses alternate A, B, A, B…
- A reserved-area boundary write by port A at address `RESERVED_WORDS-1` is blocked; one at address `RESERVED_WORDS` proceeds.

## Test plan
- **A write then read:** A writes 0x5A5A to addr 20, then reads addr 20.
  - `done_a` pulses 3 cycles after each request is seen.
  - `rdata_a` = 0x5A5A; `err_a` = 0.
- **B register area:** B writes 0x1234 to addr 3, then reads addr 3.
  - `rdata_b` = 0x1234; `mem_write_en` high exactly one cycle.
- **A blocked write:** B pre-writes 0x1111 at addr 15; A writes 0xFFFF to addr 15; B reads addr 15.
  - `err_a` pulses with `done_a`; `mem_write_en` stays 0 throughout.
  - B reads back 0x1111.
  - A write to addr 16 proceeds with `err_a` = 0.
- **Contention:** `req_a` and `req_b` held high continuously for 4 accesses.
  - Grants A, B, A, B; `done` pulses at cycles 3, 7, 11, 15.
  - The latched `mem_addr` matches the granted port each time.
- **Reset during ISSUE:** assert `reset` for one cycle while a write to addr 30 is in ISSUE.
  - No `mem_write_en`, no `done`.
  - `busy` = 0 after the edge; a later read of addr 30 returns the old value.
- **Held req after done:** port A keeps `req_a` high after `done_a`.
  - A second identical access starts in the following IDLE cycle and produces a second `done_a` 4 cycles after the first.
